training_sequencer: RTL and testbench

Controller for the perceptron training path. It stores a small training set of fixed-point (x1, x2, target) samples and, after a start pulse, streams them back-to-back for a fixed number of epochs into the neuron trainer's `train_x1_in` / `train_x2_in` / `train_out_in` / `valid_i` inputs. It holds valid continuously for the whole run so the trainer never reloads its initial weights mid-training. It pulses a capture strobe in the single cycle where the trainer's weight registers hold the final trained values.

---
 rtl/training_pkg.sv | 34 +++
 rtl/lfsr8.sv | 37 +++
 rtl/training_sequencer.sv | 148 ++++++++++++++
 tb/tb_training_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/training_pkg.sv
// Shared types for the perceptron training sequencer.
// State encoding, default sample layout and LFSR taps.
package training_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_SIGN = 1;
  localparam int DEF_Q_M  = 15;
  localparam int DEF_Q_N  = 16;

  function automatic int word_w(int s, int m, int n);
    return s + m + n;
  endfunction

  function automatic int sample_w(int w);
    return 3 * w;
  endfunction

  localparam int DEF_W = word_w(DEF_SIGN, DEF_Q_M, DEF_Q_N);

  typedef struct packed {
    logic [DEF_W-1:0] x1;
    logic [DEF_W-1:0] x2;
    logic [DEF_W-1:0] target;
  } sample_t;

  // x^8 + x^6 + x^5 + x^4 feedback taps
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR.
// Load has priority over step; reset loads the seed.
module lfsr8
  import training_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q, q_d;

  // next value: reload, shift, or hold
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = seed_i;
    end else if (step_i) begin
      q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
    end
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= seed_i;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/training_sequencer.sv
// Streams a stored training set to the neuron trainer for EPOCHS passes.
// Optional per-epoch shuffle is enabled with TRAIN_SHUFFLE_EN.
module training_sequencer
  import training_pkg::*;
#(
  parameter int          SIGN         = 1,
  parameter int          Q_M          = 15,
  parameter int          Q_N          = 16,
  parameter int          NUM_SAMPLES  = 4,
  parameter int          EPOCHS       = 1000,
  parameter logic [7:0]  SHUFFLE_SEED = 8'hA5,
  localparam int         W            = word_w(SIGN, Q_M, Q_N),
  localparam int         IDX_W        = $clog2(NUM_SAMPLES),
  localparam int         EPOCH_W      = $clog2(EPOCHS + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_addr_i,
  input  logic [W-1:0]       wr_x1_i,
  input  logic [W-1:0]       wr_x2_i,
  input  logic [W-1:0]       wr_out_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               train_valid_o,
  output logic [W-1:0]       train_x1_o,
  output logic [W-1:0]       train_x2_o,
  output logic [W-1:0]       train_out_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               capture_o,
  output logic [EPOCH_W-1:0] epoch_o
);

  typedef struct packed {
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] target;
  } smp_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               cap_q, cap_d;
  smp_t               mem_q [NUM_SAMPLES];

  logic               run;
  logic               go;
  logic               wrap;
  logic               last;
  logic [IDX_W-1:0]   mask;
  logic [IDX_W-1:0]   rd_idx;
  smp_t               rd;

  assign run  = (state_q == RUN);
  assign go   = start_i & ~abort_i & ~run;
  assign wrap = run && (idx_q == IDX_W'(NUM_SAMPLES - 1));
  assign last = wrap && (epoch_q == EPOCH_W'(EPOCHS - 1));

`ifdef TRAIN_SHUFFLE_EN
  logic [7:0] lfsr_q;

  lfsr8 u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (go),
    .seed_i  (SHUFFLE_SEED),
    .step_i  (wrap),
    .q_o     (lfsr_q)
  );

  assign mask = lfsr_q[IDX_W-1:0];
`else
  assign mask = '0;
`endif

  // next state; epoch is cleared only on start so an abort keeps it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    epoch_d = epoch_q;
    unique case (state_q)
      IDLE, DONE: begin
        idx_d = '0;
        if (go) begin
          state_d = RUN;
          epoch_d = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          if (wrap) epoch_d = epoch_q + 1'b1;
          if (last) state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    cap_d = run && (state_d == DONE);
  end

  // control registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      epoch_q <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      cap_q   <= cap_d;
    end
  end

  // sample memory, frozen while a run is streaming
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && !run) begin
      mem_q[wr_addr_i] <= '{x1: wr_x1_i,
                            x2: wr_x2_i,
                            target: wr_out_i};
    end
  end

  assign rd_idx = run ? (idx_q ^ mask) : '0;
  assign rd     = mem_q[rd_idx];

  assign train_x1_o    = rd.x1;
  assign train_x2_o    = rd.x2;
  assign train_out_o   = rd.target;
  assign train_valid_o = run;
  assign busy_o        = run;
  assign done_o        = (state_q == DONE);
  assign capture_o     = cap_q;
  assign epoch_o       = epoch_q;

endmodule

// File: tb/tb_training_sequencer.sv
// Directed bench for training_sequencer.
// Expected samples are queued at start and popped each RUN cycle.
module tb_training_sequencer;
  import training_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef TRAIN_SHUFFLE_EN
  localparam int EP = 4;
`else
  localparam int EP = 2;
`endif
  localparam int EW = $clog2(EP + 1);
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          wr_en_i;
  logic [IW-1:0] wr_addr_i;
  logic [W-1:0]  wr_x1_i, wr_x2_i, wr_out_i;
  logic          start_i, abort_i;
  logic          train_valid_o;
  logic [W-1:0]  train_x1_o, train_x2_o, train_out_o;
  logic          busy_o, done_o, capture_o;
  logic [EW-1:0] epoch_o;

  int total = 0;
  int bad   = 0;

  sample_t mdl [N];
  sample_t sb_q [$];
  int      sb_ep [$];

  always #5 clk = ~clk;

  training_sequencer #(
    .SIGN         (1),
    .Q_M          (15),
    .Q_N          (16),
    .NUM_SAMPLES  (N),
    .EPOCHS       (EP),
    .SHUFFLE_SEED (8'hA5)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_x1_i       (wr_x1_i),
    .wr_x2_i       (wr_x2_i),
    .wr_out_i      (wr_out_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .train_valid_o (train_valid_o),
    .train_x1_o    (train_x1_o),
    .train_x2_o    (train_x2_o),
    .train_out_o   (train_out_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .capture_o     (capture_o),
    .epoch_o       (epoch_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input sample_t s);
    wr_en_i   = 1'b1;
    wr_addr_i = IW'(a);
    wr_x1_i   = s.x1;
    wr_x2_i   = s.x2;
    wr_out_i  = s.target;
    tick();
    wr_en_i   = 1'b0;
    mdl[a]    = s;
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic run_full(input bit wr_mid);
    logic [7:0]    l;
    logic [IW-1:0] m;
    sample_t       e;
    int            ep;
    l = 8'hA5;
    for (int ee = 0; ee < EP; ee++) begin
`ifdef TRAIN_SHUFFLE_EN
      m = l[IW-1:0];
`else
      m = '0;
`endif
      for (int i = 0; i < N; i++) begin
        sb_q.push_back(mdl[int'(IW'(i) ^ m)]);
        sb_ep.push_back(ee);
      end
      l = lstep(l);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < EP * N; c++) begin
      if (wr_mid && c == 1) begin
        wr_en_i   = 1'b1;
        wr_addr_i = 2'd1;
        wr_x1_i   = 32'hDEAD_BEEF;
        wr_x2_i   = 32'h1234_5678;
        wr_out_i  = 32'hCAFE_F00D;
      end else begin
        wr_en_i = 1'b0;
      end
      e  = sb_q.pop_front();
      ep = sb_ep.pop_front();
      chk("run_valid", 64'(train_valid_o), 64'd1);
      chk("run_busy", 64'(busy_o), 64'd1);
      chk("run_x1", 64'(train_x1_o), 64'(e.x1));
      chk("run_x2", 64'(train_x2_o), 64'(e.x2));
      chk("run_out", 64'(train_out_o), 64'(e.target));
      chk("run_epoch", 64'(epoch_o), 64'(ep));
      chk("run_cap", 64'(capture_o), 64'd0);
      tick();
    end
    wr_en_i = 1'b0;
    chk("done_cap", 64'(capture_o), 64'd1);
    chk("done_done", 64'(done_o), 64'd1);
    chk("done_valid", 64'(train_valid_o), 64'd0);
    chk("done_busy", 64'(busy_o), 64'd0);
    chk("done_epoch", 64'(epoch_o), 64'(EP));
    tick();
    chk("done2_cap", 64'(capture_o), 64'd0);
    chk("done2_done", 64'(done_o), 64'd1);
    chk("done2_valid", 64'(train_valid_o), 64'd0);
  endtask

  initial begin
    reset_i   = 1'b1;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_x1_i   = '0;
    wr_x2_i   = '0;
    wr_out_i  = '0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    tick();
    tick();
    chk("rst_valid", 64'(train_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_cap", 64'(capture_o), 64'd0);
    chk("rst_epoch", 64'(epoch_o), 64'd0);
    chk("rst_x1", 64'(train_x1_o), 64'd0);
    reset_i = 1'b0;
    tick();

    wr(0, '{x1: '0,  x2: '0,  target: '0});
    wr(1, '{x1: '0,  x2: ONE, target: '0});
    wr(2, '{x1: ONE, x2: '0,  target: '0});
    wr(3, '{x1: ONE, x2: ONE, target: ONE});

    run_full(1'b1);
    run_full(1'b0);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abt_valid", 64'(train_valid_o), 64'd0);
    chk("abt_busy", 64'(busy_o), 64'd0);
    chk("abt_done", 64'(done_o), 64'd0);
    chk("abt_epoch", 64'(epoch_o), 64'd1);
    chk("abt_x1", 64'(train_x1_o), 64'(mdl[0].x1));
    for (int i = 0; i < 10; i++) begin
      chk("abt_cap", 64'(capture_o), 64'd0);
      chk("abt_idle_valid", 64'(train_valid_o), 64'd0);
      tick();
    end
    chk("abt_epoch_hold", 64'(epoch_o), 64'd1);

    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("sa_valid", 64'(train_valid_o), 64'd0);
    chk("sa_busy", 64'(busy_o), 64'd0);
    tick();
    chk("sa_valid2", 64'(train_valid_o), 64'd0);
    chk("sa_epoch", 64'(epoch_o), 64'd1);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    tick();
    chk("mrst_valid", 64'(train_valid_o), 64'd0);
    chk("mrst_busy", 64'(busy_o), 64'd0);
    chk("mrst_done", 64'(done_o), 64'd0);
    chk("mrst_cap", 64'(capture_o), 64'd0);
    chk("mrst_epoch", 64'(epoch_o), 64'd0);
    chk("mrst_x1", 64'(train_x1_o), 64'd0);
    chk("mrst_x2", 64'(train_x2_o), 64'd0);
    chk("mrst_out", 64'(train_out_o), 64'd0);
    reset_i = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    tick();
    run_full(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
